// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: takes resolved taken-branch updates, picks a way
// (hit, then invalid, then tree-PLRU victim) and issues a one-cycle array write.

module btb_plru_set (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_upd,
   input  logic [1:0] wr_way,
   input  logic       fe_upd,
   input  logic [1:0] fe_way,
   output logic [2:0] bits
);
   // bits = {b2,b1,b0}; an access points the tree away from the touched way
   function automatic logic [2:0] touch(input logic [2:0] b, input logic [1:0] w);
      logic [2:0] n;
      n = b;
      case (w)
         2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
         2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
         2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
         default: begin n[0] = 1'b0; n[2] = 1'b0; end
      endcase
      return n;
   endfunction

   // The controller's own write wins over a fetch hit to the same set
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         bits <= 3'b000;
      else if (wr_upd) bits <= touch(bits, wr_way);
      else if (fe_upd) bits <= touch(bits, fe_way);
   end
endmodule

module btb_update_ctrl #(
   parameter int INDEX_WIDTH = 3,
   parameter int TAG_WIDTH   = 16 - 1 - INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [15:0]            upd_pc,
   input  logic [15:0]            upd_target,
   output logic [INDEX_WIDTH-1:0] rd_index,
   input  logic [TAG_WIDTH-1:0]   tag0,
   input  logic [TAG_WIDTH-1:0]   tag1,
   input  logic [TAG_WIDTH-1:0]   tag2,
   input  logic [TAG_WIDTH-1:0]   tag3,
   input  logic [3:0]             valid_in,
   output logic                   wr_en,
   output logic [3:0]             wr_way_en,
   output logic [INDEX_WIDTH-1:0] wr_index,
   output logic [TAG_WIDTH-1:0]   wr_tag,
   output logic [15:0]            wr_target,
   input  logic                   fetch_hit,
   input  logic [INDEX_WIDTH-1:0] fetch_index,
   input  logic [1:0]             fetch_way_sel
);
   localparam int NUM_SETS = 2**INDEX_WIDTH;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   typedef struct packed {
      logic [15:1] pc;
      logic [15:0] target;
   } upd_req_t;

   upd_req_t               req_q;
   logic [1:0]             state;
   logic [1:0]             way_q, way_d;
   logic [INDEX_WIDTH-1:0] idx_q;
   logic [TAG_WIDTH-1:0]   tag_q;
   logic [NUM_SETS-1:0][2:0]           plru;
   logic [3:0][TAG_WIDTH-1:0]          rd_tag;
   logic [3:0]             tag_hit;
   logic [2:0]             set_bits;
   logic                   unused_pc0;

   // PC bit 0 is always zero for aligned instructions
   assign unused_pc0 = upd_pc[0];

   assign idx_q    = req_q.pc[INDEX_WIDTH:1];
   assign tag_q    = req_q.pc[15:16-TAG_WIDTH];
   assign rd_tag   = {tag3, tag2, tag1, tag0};
   assign set_bits = plru[idx_q];

   assign upd_ready = (state == S_IDLE);
   assign rd_index  = (state == S_IDLE) ? upd_pc[INDEX_WIDTH:1] : idx_q;
   assign wr_index  = idx_q;
   assign wr_tag    = tag_q;
   assign wr_target = req_q.target;

   always_comb begin
      for (int w = 0; w < 4; w++) tag_hit[w] = valid_in[w] & (rd_tag[w] == tag_q);
   end

   // Later assignments override: victim < lowest invalid < lowest hit
   always_comb begin
      way_d = set_bits[0] ? {1'b1, set_bits[2]} : {1'b0, set_bits[1]};
      for (int w = 3; w >= 0; w--) if (!valid_in[w]) way_d = 2'(w);
      for (int w = 3; w >= 0; w--) if (tag_hit[w])   way_d = 2'(w);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         req_q     <= '0;
         way_q     <= 2'd0;
         wr_en     <= 1'b0;
         wr_way_en <= 4'b0000;
      end else begin
         wr_en     <= 1'b0;
         wr_way_en <= 4'b0000;
         case (state)
            S_IDLE: if (upd_valid) begin
               req_q <= '{pc: upd_pc[15:1], target: upd_target};
               state <= S_READ;
            end
            S_READ: begin
               way_q     <= way_d;
               wr_en     <= 1'b1;
               wr_way_en <= 4'b0001 << way_d;
               state     <= S_WRITE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
      btb_plru_set u_plru (
         .clk    (clk),
         .rst    (rst),
         .wr_upd (wr_en && (idx_q == INDEX_WIDTH'(s))),
         .wr_way (way_q),
         .fe_upd (fetch_hit && (fetch_index == INDEX_WIDTH'(s))),
         .fe_way (fetch_way_sel),
         .bits   (plru[s])
      );
   end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus random
// updates against a "most recently touched" model of the tree PLRU.

module tb_btb_update_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        upd_valid, upd_ready;
   logic [15:0] upd_pc, upd_target;
   logic [2:0]  rd_index;
   logic [11:0] tag0, tag1, tag2, tag3;
   logic [3:0]  valid_in;
   logic        wr_en;
   logic [3:0]  wr_way_en;
   logic [2:0]  wr_index;
   logic [11:0] wr_tag;
   logic [15:0] wr_target;
   logic        fetch_hit;
   logic [2:0]  fetch_index;
   logic [1:0]  fetch_way_sel;

   int errors = 0;
   int checks = 0;

   // Model: which half was touched last, and which way inside each half
   int last_pair[8];
   int last01[8];
   int last23[8];

   btb_update_ctrl dut (
      .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_target(upd_target), .rd_index(rd_index),
      .tag0(tag0), .tag1(tag1), .tag2(tag2), .tag3(tag3), .valid_in(valid_in),
      .wr_en(wr_en), .wr_way_en(wr_way_en), .wr_index(wr_index), .wr_tag(wr_tag),
      .wr_target(wr_target), .fetch_hit(fetch_hit), .fetch_index(fetch_index),
      .fetch_way_sel(fetch_way_sel)
   );

   always #5 clk = ~clk;

   function automatic void m_reset();
      for (int s = 0; s < 8; s++) begin
         last_pair[s] = 1; last01[s] = 1; last23[s] = 3;
      end
   endfunction

   function automatic int m_victim(input int s);
      if (last_pair[s] == 1) return (last01[s] == 0) ? 1 : 0;
      return (last23[s] == 2) ? 3 : 2;
   endfunction

   function automatic void m_touch(input int s, input int w);
      if (w < 2) begin last_pair[s] = 0; last01[s] = w; end
      else begin last_pair[s] = 1; last23[s] = w; end
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One full update; entered and left at posedge+1 in IDLE. Returns observed wr_way_en.
   task automatic do_update(input logic [15:0] pc, input logic [15:0] tgt, input logic [3:0] vld,
                            input logic [11:0] t0, input logic [11:0] t1,
                            input logic [11:0] t2, input logic [11:0] t3,
                            input logic fe, input logic [2:0] fe_idx, input logic [1:0] fe_way,
                            output logic [3:0] got);
      logic [11:0] tg[4];
      logic [11:0] ptag;
      int idx, ew;
      tg[0] = t0; tg[1] = t1; tg[2] = t2; tg[3] = t3;
      ptag = pc[15:4];
      idx = int'(pc[3:1]);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
      #1;
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready act=%b exp=1", upd_ready); end
      checks++; if (rd_index !== pc[3:1]) begin errors++; $display("FAIL idle_rd_index act=%0d exp=%0d", rd_index, idx); end
      tick();
      upd_valid = 1'b0; upd_pc = 16'($urandom);
      valid_in = vld; tag0 = t0; tag1 = t1; tag2 = t2; tag3 = t3;
      #1;
      checks++; if (upd_ready !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL read_cycle ready=%b wr_en=%b exp 0/0", upd_ready, wr_en); end
      checks++; if (rd_index !== pc[3:1]) begin errors++; $display("FAIL read_rd_index act=%0d exp=%0d", rd_index, idx); end
      ew = -1;
      for (int w = 0; w < 4; w++) if (ew < 0 && vld[w] && tg[w] == ptag) ew = w;
      for (int w = 0; w < 4; w++) if (ew < 0 && !vld[w]) ew = w;
      if (ew < 0) ew = m_victim(idx);
      tick();
      fetch_hit = fe; fetch_index = fe_idx; fetch_way_sel = fe_way;
      valid_in = 4'($urandom);
      #1;
      got = wr_way_en;
      checks++; if (wr_en !== 1'b1 || upd_ready !== 1'b0) begin errors++; $display("FAIL write_cycle wr_en=%b ready=%b exp 1/0", wr_en, upd_ready); end
      checks++; if (wr_way_en !== (4'b0001 << ew)) begin errors++; $display("FAIL wr_way_en act=%b exp=%b", wr_way_en, 4'b0001 << ew); end
      checks++; if (wr_index !== pc[3:1] || wr_tag !== ptag || wr_target !== tgt) begin
         errors++; $display("FAIL wr_fields act=%0d/%h/%h exp=%0d/%h/%h", wr_index, wr_tag, wr_target, idx, ptag, tgt); end
      tick();
      m_touch(idx, ew);
      if (fe && int'(fe_idx) != idx) m_touch(int'(fe_idx), int'(fe_way));
      fetch_hit = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b0 || wr_way_en !== 4'b0000 || upd_ready !== 1'b1) begin
         errors++; $display("FAIL after_write wr_en=%b way_en=%b ready=%b exp 0/0000/1", wr_en, wr_way_en, upd_ready); end
   endtask

   task automatic idle_fetch(input logic [2:0] idx, input logic [1:0] w);
      fetch_hit = 1'b1; fetch_index = idx; fetch_way_sel = w;
      tick();
      m_touch(int'(idx), int'(w));
      fetch_hit = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; upd_valid = 1'b0; upd_pc = 16'h0; upd_target = 16'h0;
      valid_in = 4'h0; tag0 = '0; tag1 = '0; tag2 = '0; tag3 = '0;
      fetch_hit = 1'b0; fetch_index = '0; fetch_way_sel = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wr_en !== 1'b0 || wr_way_en !== 4'b0000) begin errors++; $display("FAIL reset_wr act=%b/%b exp=0/0000", wr_en, wr_way_en); end
      checks++; if (wr_index !== 3'd0 || wr_tag !== 12'h0 || wr_target !== 16'h0) begin
         errors++; $display("FAIL reset_fields act=%0d/%h/%h exp=0/0/0", wr_index, wr_tag, wr_target); end
      rst = 1'b0;
      tick();
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready act=%b exp=1", upd_ready); end
   endtask

   task automatic test_plru_seq();
      logic [3:0] g;
      do_update(16'h5000, 16'h1111, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL plru_seq1 act=%b exp=0001", g); end
      do_update(16'h5000, 16'h2222, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0100) begin errors++; $display("FAIL plru_seq2 act=%b exp=0100", g); end
      do_update(16'h5000, 16'h3333, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0010) begin errors++; $display("FAIL plru_seq3 act=%b exp=0010", g); end
   endtask

   task automatic test_basic();
      logic [3:0] g;
      do_update(16'h3002, 16'h3100, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL basic_way act=%b exp=0001", g); end
   endtask

   task automatic test_hit_priority();
      logic [3:0] g;
      do_update(16'h3002, 16'h3200, 4'hf, 12'h301, 12'h302, 12'h300, 12'h300, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0100) begin errors++; $display("FAIL hit_priority act=%b exp=0100", g); end
      do_update(16'h3002, 16'h3300, 4'hf, 12'h301, 12'h302, 12'h303, 12'h304, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0010) begin errors++; $display("FAIL hit_then_victim act=%b exp=0010", g); end
   endtask

   task automatic test_fetch_collide();
      logic [3:0] g;
      do_update(16'h5000, 16'h4000, 4'hf, 12'h111, 12'h222, 12'h333, 12'h500, 1'b1, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b1000) begin errors++; $display("FAIL fetch_same_hit act=%b exp=1000", g); end
      do_update(16'h5000, 16'h4100, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL fetch_same_victim act=%b exp=0001", g); end
      do_update(16'h5000, 16'h4200, 4'hf, 12'h111, 12'h222, 12'h333, 12'h500, 1'b1, 3'd5, 2'd0, g);
      checks++; if (g !== 4'b1000) begin errors++; $display("FAIL fetch_diff_hit act=%b exp=1000", g); end
      do_update(16'h5000, 16'h4300, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0010) begin errors++; $display("FAIL fetch_diff_set0 act=%b exp=0010", g); end
      do_update(16'h500a, 16'h4400, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0100) begin errors++; $display("FAIL fetch_diff_set5 act=%b exp=0100", g); end
   endtask

   task automatic test_back_to_back();
      int acc, pulses;
      acc = 0; pulses = 0;
      upd_valid = 1'b1; upd_pc = 16'h700c; upd_target = 16'h7777; valid_in = 4'h0;
      for (int i = 0; i < 12; i++) begin
         checks++; if (upd_ready !== (i % 3 == 0)) begin errors++; $display("FAIL b2b_ready cyc=%0d act=%b exp=%b", i, upd_ready, i % 3 == 0); end
         checks++; if (wr_en !== (i % 3 == 2)) begin errors++; $display("FAIL b2b_wr_en cyc=%0d act=%b exp=%b", i, wr_en, i % 3 == 2); end
         if (upd_valid && upd_ready) acc++;
         if (wr_en) begin
            pulses++;
            checks++; if (wr_way_en !== 4'b0001) begin errors++; $display("FAIL b2b_way act=%b exp=0001", wr_way_en); end
            m_touch(6, 0);
         end
         tick();
      end
      upd_valid = 1'b0;
      checks++; if (acc != 4 || pulses != 4) begin errors++; $display("FAIL b2b_counts act=%0d/%0d exp=4/4", acc, pulses); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] g;
      upd_valid = 1'b1; upd_pc = 16'h3002; upd_target = 16'h1234;
      tick();
      upd_valid = 1'b0; valid_in = 4'h0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en cyc=%0d act=%b exp=0", i, wr_en); end
         tick();
      end
      rst = 1'b0; m_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (wr_en !== 1'b0 || upd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after wr_en=%b ready=%b exp 0/1", wr_en, upd_ready); end
         tick();
      end
      do_update(16'h3002, 16'h5678, 4'hf, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 3'd0, 2'd0, g);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rst_mid_plru act=%b exp=0001", g); end
   endtask

   task automatic test_random();
      logic [15:0] pc;
      logic [11:0] pt, t[4];
      logic [3:0]  g;
      for (int i = 0; i < 60; i++) begin
         pc = 16'($urandom);
         pt = pc[15:4];
         for (int w = 0; w < 4; w++) t[w] = ($urandom_range(0, 2) == 0) ? pt : (pt ^ 12'(w + 1));
         do_update(pc, 16'($urandom), 4'($urandom), t[0], t[1], t[2], t[3],
                   1'($urandom), 3'($urandom), 2'($urandom), g);
         if ($urandom_range(0, 1) == 1) idle_fetch(3'($urandom), 2'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_plru_seq();
      test_basic();
      test_hit_priority();
      test_fetch_collide();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller for the 4-way branch target buffer. It is the counterpart of the fetch-side hit encoder: that encoder turns way hits into a 2-bit target-mux select, while this block turns a 2-bit way choice into one-hot way write enables.
- Accepts resolved taken-branch updates from the execute stage and reads the set's tags and valids through the arrays' synchronous read port.
- Chooses a way (hit, then invalid, then pseudo-LRU victim) and issues a single-cycle write.
- Keeps per-set tree pseudo-LRU state, updated by both its own writes and fetch-side hits.

Parameters:
- INDEX_WIDTH, 3, set index bits taken from PC[INDEX_WIDTH:1]. NUM_SETS = 2**INDEX_WIDTH.
- TAG_WIDTH, 12, tag bits taken from PC[15:16-TAG_WIDTH]. Fixed by 16 - 1 - INDEX_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- upd_valid  in  1  resolved taken branch requests a BTB update.
- upd_ready  out  1  controller can accept an update.
- upd_pc  in  16  branch PC (lc3b_word).
- upd_target  in  16  branch target (lc3b_word).
- rd_index  out  INDEX_WIDTH  array read set index; data returns on the next cycle.
- tag0, tag1, tag2, tag3  in  TAG_WIDTH each  per-way tags read for rd_index.
- valid_in  in  4  per-way valid bits read for rd_index.
- wr_en  out  1  array write strobe.
- wr_way_en  out  4  one-hot way write enable.
- wr_index  out  INDEX_WIDTH  set being written.
- wr_tag  out  TAG_WIDTH  tag to write.
- wr_target  out  16  target to write.
- fetch_hit  in  1  fetch-side BTB hit this cycle.
- fetch_index  in  INDEX_WIDTH  set of the fetch hit.
- fetch_way_sel  in  2  hitting way, the encoder's mux select.

Behaviour:
- Reset (async):
  - FSM goes to IDLE.
  - All PLRU bits clear.
  - wr_en=0, wr_way_en=0000, wr_index/wr_tag/wr_target=0.
  - upd_ready=1 once rst deasserts.
  - Reset in any state abandons the update in flight; no write is issued.
- FSM states:
  - IDLE:
    - upd_ready=1; rd_index=upd_pc[INDEX_WIDTH:1] combinationally.
    - On upd_valid, latch pc/target and go to READ. The handshake is upd_valid & upd_ready.
  - READ:
    - upd_ready=0; rd_index=latched index; array data is valid this cycle.
    - Way choice, in priority order:
      1. Lowest-numbered way with valid_in[w] and tag_w == latched tag (same priority as the fetch encoder).
      2. Otherwise the lowest-numbered way with valid_in[w]=0.
      3. Otherwise the PLRU victim of the set.
    - Register the chosen way as a 2-bit index and go to WRITE.
  - WRITE:
    - upd_ready=0; wr_en=1 for exactly this cycle.
    - wr_way_en = one-hot decode of the chosen way; wr_index/wr_tag/wr_target come from latched values.
    - Update the set's PLRU to mark the chosen way MRU, then go to IDLE.
- Timing: handshake at cycle N, write at cycle N+2, next accept possible at N+3. Outputs are registered or state-decoded; wr_en is glitch-free.
- PLRU, 3 bits per set {b2,b1,b0}:
  - Victim selection: b0=0 picks from ways {0,1}, with b1=0→way0 and b1=1→way1. b0=1 picks from ways {2,3}, with b2=0→way2 and b2=1→way3.
  - Update on access:
    - way0: b0=1, b1=1
    - way1: b0=1, b1=0
    - way2: b0=0, b2=1
    - way3: b0=0, b2=0
  - Untouched bits hold.
- Fetch hits: on fetch_hit, apply the access update for fetch_way_sel to fetch_index in the same cycle, independent of FSM state.
- Simultaneous fetch update and WRITE update:
  - Same set: the WRITE update alone is applied and the fetch update is dropped.
  - Different sets: both are applied.
- The block does not clear array valids; the arrays own their reset.

Test Plan:
- Reset, then update pc=0x3002 tgt=0x3100 with valid_in=0000 → upd_ready low for 2 cycles; at N+2 wr_en=1, wr_way_en=0001, wr_index=1, wr_tag=0x300, wr_target=0x3100.
- valid_in=1111, tag2=tag3=0x300, pc=0x3002 → wr_way_en=0100 (lowest hit wins); PLRU of set 1 becomes b0=0, b2=1.
- Set 0 from reset, all valid, no tag match, three successive updates → ways written 0001, then 0100, then 0010.
- fetch_hit with fetch_index=0 and fetch_way_sel=00 in the same cycle as a WRITE to set 0 way 3 → set 0 PLRU = 000; next miss victim is way0. Repeat with fetch_index=5 → both sets updated.
- upd_valid held high continuously → exactly one accept every 3 cycles, one wr_en pulse each, and no accept during READ or WRITE.
- rst pulsed during READ → no wr_en pulse, all PLRU state cleared, upd_ready=1 once rst deasserts, and the next update proceeds normally.
